// File: rtl/gcd_multi_coprocessor_pkg.sv
// gcd_multi_coprocessor_pkg
// Shared definitions for the multi-engine GCD coprocessor: the per-engine
// state encoding and a helper that sizes round-robin pointers.
// No ports; imported by gcd_unit and gcd_multi_coprocessor.
package gcd_multi_coprocessor_pkg;

    // Engine life cycle: waiting for work, iterating, holding a finished result.
    typedef enum logic [1:0] {
        UNIT_IDLE = 2'd0,
        UNIT_CALC = 2'd1,
        UNIT_DONE = 2'd2
    } unit_state_t;

    // Width of a pointer that selects one of n items. It is never zero,
    // so a single-engine build still has a legal 1-bit pointer.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gcd_multi_coprocessor_unit.sv
// gcd_unit
// One iterative subtract-and-swap GCD engine.
// Ports:
//   clk, reset       clock and synchronous active-low reset
//   i_load, i_a, i_b start a new operand pair (honoured only while idle)
//   i_collect        result has been taken; return to idle (honoured only while done)
//   o_idle, o_done   engine state flags
//   o_result         GCD value, valid while o_done is high
module gcd_unit
    import gcd_multi_coprocessor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_collect,
    output logic             o_idle,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    unit_state_t      r_state;
    unit_state_t      w_nextState;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_nextA;
    logic [WIDTH-1:0] w_nextB;

    // State and operand registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= UNIT_IDLE;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_nextState;
            r_a     <= w_nextA;
            r_b     <= w_nextB;
        end
    end

    // One algorithm step per cycle. A is always kept >= B before subtracting,
    // so the subtraction can never wrap. B reaching zero leaves the answer in A.
    always_comb begin
        w_nextState = r_state;
        w_nextA     = r_a;
        w_nextB     = r_b;
        case (r_state)
            UNIT_IDLE: begin
                if (i_load) begin
                    w_nextState = UNIT_CALC;
                    w_nextA     = i_a;
                    w_nextB     = i_b;
                end
            end
            UNIT_CALC: begin
                if (r_a < r_b) begin
                    w_nextA = r_b;
                    w_nextB = r_a;
                end else if (r_b != '0) begin
                    w_nextA = r_a - r_b;
                end else begin
                    w_nextState = UNIT_DONE;
                end
            end
            UNIT_DONE: begin
                if (i_collect) begin
                    w_nextState = UNIT_IDLE;
                end
            end
            default: begin
                w_nextState = UNIT_IDLE;
            end
        endcase
    end

    assign o_idle   = (r_state == UNIT_IDLE);
    assign o_done   = (r_state == UNIT_DONE);
    assign o_result = r_a;

endmodule

// File: rtl/gcd_multi_coprocessor.sv
// gcd_multi_coprocessor
// Multi-engine GCD coprocessor. Operand pairs enter an input FIFO, are handed
// round-robin to NUM_UNITS engines, and are collected with a matching
// round-robin pointer into an output FIFO, so results leave in arrival order.
// Ports:
//   clk, reset                              clock, synchronous active-low reset
//   operands_val/_rdy, operands_bits_A/_B   operand pair handshake
//   result_val/_rdy, result_bits            result handshake (output FIFO head)
//   in_flight                               pairs accepted but not yet delivered
module gcd_multi_coprocessor
    import gcd_multi_coprocessor_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_UNITS = 2,
    parameter int DEPTH     = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   operands_val,
    input  logic [WIDTH-1:0]                       operands_bits_A,
    input  logic [WIDTH-1:0]                       operands_bits_B,
    output logic                                   operands_rdy,
    output logic                                   result_val,
    output logic [WIDTH-1:0]                       result_bits,
    input  logic                                   result_rdy,
    output logic [$clog2(2*DEPTH+NUM_UNITS+1)-1:0] in_flight
);

    localparam int UPTR_W = ptrWidth(NUM_UNITS);
    localparam int FPTR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IF_W   = $clog2(2*DEPTH + NUM_UNITS + 1);

    logic [2*WIDTH-1:0] r_inMem [DEPTH];
    logic [FPTR_W-1:0]  r_inWr;
    logic [FPTR_W-1:0]  r_inRd;
    logic [CNT_W-1:0]   r_inCount;
    logic [WIDTH-1:0]   r_outMem [DEPTH];
    logic [FPTR_W-1:0]  r_outWr;
    logic [FPTR_W-1:0]  r_outRd;
    logic [CNT_W-1:0]   r_outCount;
    logic [UPTR_W-1:0]  r_dispatchPtr;
    logic [UPTR_W-1:0]  r_collectPtr;
    logic [IF_W-1:0]    r_inFlight;

    logic [NUM_UNITS-1:0] w_unitIdle;
    logic [NUM_UNITS-1:0] w_unitDone;
    logic [WIDTH-1:0]     w_unitResult [NUM_UNITS];
    logic [2*WIDTH-1:0]   w_inHead;
    logic                 w_accept;
    logic                 w_dispatch;
    logic                 w_collect;
    logic                 w_deliver;
    logic                 w_outHasData;

    function automatic logic [UPTR_W-1:0] advance(input logic [UPTR_W-1:0] p);
        return (p == UPTR_W'(NUM_UNITS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake outputs are forced low while reset is held so nothing is
    // offered or accepted before the state registers have been cleared.
    assign w_outHasData = (r_outCount != '0);
    assign operands_rdy = reset && (r_inCount != CNT_W'(DEPTH));
    assign result_val   = reset && w_outHasData;
    assign result_bits  = (reset && w_outHasData) ? r_outMem[r_outRd] : '0;
    assign in_flight    = r_inFlight;

    assign w_accept   = operands_val && operands_rdy;
    assign w_deliver  = result_val && result_rdy;
    assign w_inHead   = r_inMem[r_inRd];
    assign w_dispatch = (r_inCount != '0) && w_unitIdle[r_dispatchPtr];
    assign w_collect  = w_unitDone[r_collectPtr] && (r_outCount != CNT_W'(DEPTH));

    // Engines. Only the engine under the dispatch pointer may be loaded and
    // only the one under the collect pointer may be drained; a finished
    // engine elsewhere waits its turn, which is what keeps results ordered.
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        gcd_unit #(
            .WIDTH(WIDTH)
        ) u_unit (
            .clk       (clk),
            .reset     (reset),
            .i_load    (w_dispatch && (r_dispatchPtr == UPTR_W'(g))),
            .i_a       (w_inHead[2*WIDTH-1:WIDTH]),
            .i_b       (w_inHead[WIDTH-1:0]),
            .i_collect (w_collect && (r_collectPtr == UPTR_W'(g))),
            .o_idle    (w_unitIdle[g]),
            .o_done    (w_unitDone[g]),
            .o_result  (w_unitResult[g])
        );
    end

    // FIFO storage needs no reset: the counts decide what is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_inMem[r_inWr] <= {operands_bits_A, operands_bits_B};
        end
        if (w_collect) begin
            r_outMem[r_outWr] <= w_unitResult[r_collectPtr];
        end
    end

    // FIFO pointers and counts, round-robin pointers, and the in-flight
    // counter. DEPTH is a power of two, so FIFO pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_inWr        <= '0;
            r_inRd        <= '0;
            r_inCount     <= '0;
            r_outWr       <= '0;
            r_outRd       <= '0;
            r_outCount    <= '0;
            r_dispatchPtr <= '0;
            r_collectPtr  <= '0;
            r_inFlight    <= '0;
        end else begin
            if (w_accept) begin
                r_inWr <= r_inWr + 1'b1;
            end
            if (w_dispatch) begin
                r_inRd        <= r_inRd + 1'b1;
                r_dispatchPtr <= advance(r_dispatchPtr);
            end
            if (w_collect) begin
                r_outWr      <= r_outWr + 1'b1;
                r_collectPtr <= advance(r_collectPtr);
            end
            if (w_deliver) begin
                r_outRd <= r_outRd + 1'b1;
            end
            r_inCount  <= r_inCount + CNT_W'(w_accept) - CNT_W'(w_dispatch);
            r_outCount <= r_outCount + CNT_W'(w_collect) - CNT_W'(w_deliver);
            r_inFlight <= r_inFlight + IF_W'(w_accept) - IF_W'(w_deliver);
        end
    end

endmodule
